// File: rtl/ctrl_edicion_rtc.sv
// rtl/ctrl_edicion_rtc.sv - keyboard edit sequencer for the RTC field counters
// Turns PS/2 make codes into mode flags, field cursor, up/down strobes and a commit strobe.
module ctrl_edicion_rtc #(
    parameter int          N       = 8,
    parameter int          P       = 2,
    parameter int          NPOS    = 3,
    parameter int unsigned TIMEOUT = 32'd1_000_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [N-1:0] key_code,
    output logic [P-1:0] posicion,
    output logic         f1,
    output logic         f2,
    output logic         f3,
    output logic         en_codigo,
    output logic [N-1:0] key_code_out,
    output logic         wr_rtc,
    output logic [1:0]   wr_sel
);

    localparam logic [N-1:0] K_F1    = N'(8'h05);
    localparam logic [N-1:0] K_F2    = N'(8'h06);
    localparam logic [N-1:0] K_F3    = N'(8'h04);
    localparam logic [N-1:0] K_LEFT  = N'(8'h6B);
    localparam logic [N-1:0] K_RIGHT = N'(8'h74);
    localparam logic [N-1:0] K_UP    = N'(8'h75);
    localparam logic [N-1:0] K_DOWN  = N'(8'h72);
    localparam logic [N-1:0] K_ENTER = N'(8'h5A);
    localparam logic [N-1:0] K_ESC   = N'(8'h76);

    localparam logic [31:0]  TERM = 32'(TIMEOUT - 1);
    localparam logic [P-1:0] LAST = P'(NPOS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ED_HORA,
        ED_FECHA,
        ED_TIMER,
        COMMIT
    } state_t;

    state_t       state, state_nx;
    logic [31:0]  cnt, cnt_nx;
    logic [P-1:0] pos_nx;
    logic         en_nx;
    logic [N-1:0] kco_nx;
    logic         wr_nx;
    logic [1:0]   sel_nx;
    logic [1:0]   mode_sel;

    assign mode_sel = (state == ED_HORA)  ? 2'd1 :
                      (state == ED_FECHA) ? 2'd2 : 2'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            posicion     <= '0;
            f1           <= 1'b0;
            f2           <= 1'b0;
            f3           <= 1'b0;
            en_codigo    <= 1'b0;
            key_code_out <= '0;
            wr_rtc       <= 1'b0;
            wr_sel       <= 2'd0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            posicion     <= pos_nx;
            // Flags follow the next state so they line up with the state register.
            f1           <= (state_nx == ED_HORA);
            f2           <= (state_nx == ED_FECHA);
            f3           <= (state_nx == ED_TIMER);
            en_codigo    <= en_nx;
            key_code_out <= kco_nx;
            wr_rtc       <= wr_nx;
            wr_sel       <= sel_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pos_nx   = posicion;
        cnt_nx   = '0;
        en_nx    = 1'b0;
        kco_nx   = key_code_out;
        wr_nx    = 1'b0;
        sel_nx   = 2'd0;
        case (state)
            IDLE: begin
                pos_nx = '0;
                if (key_valid) begin
                    case (key_code)
                        K_F1:    state_nx = ED_HORA;
                        K_F2:    state_nx = ED_FECHA;
                        K_F3:    state_nx = ED_TIMER;
                        default: state_nx = IDLE;
                    endcase
                end
            end
            ED_HORA, ED_FECHA, ED_TIMER: begin
                if (key_valid) begin
                    // Any key, recognised or not, restarts the idle count (cnt_nx stays 0).
                    case (key_code)
                        K_F1: if (state != ED_HORA) begin
                            state_nx = ED_HORA;
                            pos_nx   = '0;
                        end
                        K_F2: if (state != ED_FECHA) begin
                            state_nx = ED_FECHA;
                            pos_nx   = '0;
                        end
                        K_F3: if (state != ED_TIMER) begin
                            state_nx = ED_TIMER;
                            pos_nx   = '0;
                        end
                        K_RIGHT: pos_nx = (posicion == LAST) ? '0 : posicion + P'(1);
                        K_LEFT:  pos_nx = (posicion == '0) ? LAST : posicion - P'(1);
                        K_UP, K_DOWN: begin
                            en_nx  = 1'b1;
                            kco_nx = key_code;
                        end
                        K_ENTER: begin
                            state_nx = COMMIT;
                            pos_nx   = '0;
                            wr_nx    = 1'b1;
                            sel_nx   = mode_sel;
                        end
                        K_ESC: begin
                            state_nx = IDLE;
                            pos_nx   = '0;
                        end
                        default: pos_nx = posicion;
                    endcase
                end else if (cnt == TERM) begin
                    state_nx = IDLE;
                    pos_nx   = '0;
                end else begin
                    cnt_nx = cnt + 32'd1;
                end
            end
            COMMIT: begin
                state_nx = IDLE;
                pos_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                pos_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_edicion_rtc.sv
// tb/tb_ctrl_edicion_rtc.sv - randomized and directed bench for ctrl_edicion_rtc
// A mode/cursor/idle-count reference model predicts every registered output.
module tb_ctrl_edicion_rtc;

    localparam int TO = 20;
    localparam int NP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic [1:0] posicion;
    logic       f1, f2, f3, en_codigo, wr_rtc;
    logic [7:0] key_code_out;
    logic [1:0] wr_sel;

    int total = 0;
    int bad = 0;

    ctrl_edicion_rtc #(.N(8), .P(2), .NPOS(NP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .posicion(posicion), .f1(f1), .f2(f2), .f3(f3),
        .en_codigo(en_codigo), .key_code_out(key_code_out),
        .wr_rtc(wr_rtc), .wr_sel(wr_sel)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=idle 1=hora 2=fecha 3=timer, plus a commit-in-progress flag.
    int         m_mode, m_pos, m_idle;
    bit         m_commit;
    logic       exp_en, exp_wr;
    logic [7:0] exp_kco;
    logic [1:0] exp_wsel;
    logic [7:0] key_tab [0:8];

    function automatic int fmode(input logic [7:0] kc);
        if (kc == 8'h05) return 1;
        if (kc == 8'h06) return 2;
        if (kc == 8'h04) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_idle = 0; m_commit = 0;
        exp_en = 0; exp_wr = 0; exp_kco = 8'h00; exp_wsel = 2'd0;
    endtask

    task automatic model_step(input logic kv, input logic [7:0] kc);
        int fm;
        exp_en = 0; exp_wr = 0; exp_wsel = 2'd0;
        fm = fmode(kc);
        if (m_commit) begin
            m_commit = 0; m_mode = 0; m_pos = 0;
        end else if (m_mode == 0) begin
            if (kv && fm != 0) begin m_mode = fm; m_pos = 0; m_idle = 0; end
        end else if (kv) begin
            m_idle = 0;
            if (fm != 0) begin
                if (fm != m_mode) begin m_mode = fm; m_pos = 0; end
            end else if (kc == 8'h74) m_pos = (m_pos + 1) % NP;
            else if (kc == 8'h6B) m_pos = (m_pos + NP - 1) % NP;
            else if (kc == 8'h75 || kc == 8'h72) begin exp_en = 1; exp_kco = kc; end
            else if (kc == 8'h5A) begin
                exp_wr = 1; exp_wsel = 2'(m_mode); m_commit = 1; m_pos = 0;
            end else if (kc == 8'h76) begin m_mode = 0; m_pos = 0; end
        end else begin
            m_idle++;
            if (m_idle == TO) begin m_mode = 0; m_pos = 0; end
        end
    endtask

    task automatic press(input logic kv, input logic [7:0] kc);
        @(negedge clk);
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        model_step(kv, kc);
        #1;
    endtask

    task automatic do_reset();
        key_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({f1, f2, f3} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {f1, f2, f3}); end
        total++; if (posicion !== 2'd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", posicion); end
        total++; if ({en_codigo, wr_rtc} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {en_codigo, wr_rtc}); end
        total++; if (key_code_out !== 8'h00 || wr_sel !== 2'd0) begin bad++; $display("FAIL reset_regs got=%h/%0d want=00/0", key_code_out, wr_sel); end
    endtask

    task automatic test_navigation();
        logic [1:0] want [0:2];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd0;
        press(1, 8'h05);
        total++; if (f1 !== 1'b1 || posicion !== 2'd0) begin bad++; $display("FAIL nav_entry got=f1 %b pos %0d want=f1 1 pos 0", f1, posicion); end
        for (int i = 0; i < 3; i++) begin
            press(1, 8'h74);
            total++; if (posicion !== want[i]) begin bad++; $display("FAIL nav_right%0d got=%0d want=%0d", i, posicion, want[i]); end
        end
        press(1, 8'h6B);
        total++; if (posicion !== 2'd2) begin bad++; $display("FAIL nav_left_wrap got=%0d want=2", posicion); end
    endtask

    task automatic test_updown();
        press(1, 8'h75);
        total++; if (en_codigo !== 1'b1 || key_code_out !== 8'h75) begin bad++; $display("FAIL up_strobe got=en %b code %h want=en 1 code 75", en_codigo, key_code_out); end
        total++; if (f1 !== 1'b1 || posicion !== 2'd2) begin bad++; $display("FAIL up_hold got=f1 %b pos %0d want=f1 1 pos 2", f1, posicion); end
        press(0, 8'h00);
        total++; if (en_codigo !== 1'b0) begin bad++; $display("FAIL up_one_cycle got=%b want=0", en_codigo); end
        press(1, 8'h72);
        total++; if (en_codigo !== 1'b1 || key_code_out !== 8'h72) begin bad++; $display("FAIL down_strobe got=en %b code %h want=en 1 code 72", en_codigo, key_code_out); end
    endtask

    task automatic test_switch_commit();
        press(1, 8'h04);
        total++; if ({f1, f2, f3} !== 3'b001 || posicion !== 2'd0 || wr_rtc !== 1'b0) begin bad++; $display("FAIL switch_f3 got=%b pos %0d wr %b want=001 pos 0 wr 0", {f1, f2, f3}, posicion, wr_rtc); end
        press(1, 8'h04);
        press(1, 8'h74);
        press(1, 8'h5A);
        total++; if (wr_rtc !== 1'b1 || wr_sel !== 2'd3) begin bad++; $display("FAIL commit_pulse got=wr %b sel %0d want=wr 1 sel 3", wr_rtc, wr_sel); end
        total++; if ({f1, f2, f3} !== 3'b000 || posicion !== 2'd0) begin bad++; $display("FAIL commit_flags got=%b pos %0d want=000 pos 0", {f1, f2, f3}, posicion); end
        press(1, 8'h5A);
        total++; if (wr_rtc !== 1'b0 || wr_sel !== 2'd0 || {f1, f2, f3} !== 3'b000) begin bad++; $display("FAIL commit_drop got=wr %b sel %0d flags %b want=0 0 000", wr_rtc, wr_sel, {f1, f2, f3}); end
        press(0, 8'h00);
        total++; if (wr_rtc !== 1'b0) begin bad++; $display("FAIL commit_once got=%b want=0", wr_rtc); end
    endtask

    task automatic test_esc_idle();
        logic [7:0] idle_keys [0:2];
        idle_keys[0] = 8'h75; idle_keys[1] = 8'h6B; idle_keys[2] = 8'h5A;
        press(1, 8'h06);
        total++; if (f2 !== 1'b1 || wr_rtc !== 1'b0) begin bad++; $display("FAIL esc_enter got=f2 %b wr %b want=1 0", f2, wr_rtc); end
        press(1, 8'h76);
        total++; if ({f1, f2, f3} !== 3'b000 || wr_rtc !== 1'b0) begin bad++; $display("FAIL esc_exit got=%b wr %b want=000 0", {f1, f2, f3}, wr_rtc); end
        for (int i = 0; i < 3; i++) begin
            press(1, idle_keys[i]);
            total++; if ({f1, f2, f3, en_codigo, wr_rtc} !== 5'b0 || posicion !== 2'd0) begin bad++; $display("FAIL idle_key%0d got=%b pos %0d want=00000 pos 0", i, {f1, f2, f3, en_codigo, wr_rtc}, posicion); end
        end
    endtask

    task automatic test_timeout();
        press(1, 8'h05);
        for (int i = 1; i < TO; i++) begin
            press(0, 8'h00);
            total++; if (f1 !== 1'b1) begin bad++; $display("FAIL to_hold%0d got=%b want=1", i, f1); end
        end
        press(0, 8'h00);
        total++; if (f1 !== 1'b0 || wr_rtc !== 1'b0) begin bad++; $display("FAIL to_expire got=f1 %b wr %b want=0 0", f1, wr_rtc); end
        press(1, 8'h05);
        for (int i = 1; i < TO - 1; i++) press(0, 8'h00);
        press(1, 8'h00);
        for (int i = 1; i < TO; i++) press(0, 8'h00);
        total++; if (f1 !== 1'b1) begin bad++; $display("FAIL to_restart got=%b want=1", f1); end
        press(0, 8'h00);
        total++; if (f1 !== 1'b0) begin bad++; $display("FAIL to_restart_expire got=%b want=0", f1); end
        press(1, 8'h05);
        for (int i = 1; i < TO; i++) press(0, 8'h00);
        press(1, 8'h74);
        total++; if (f1 !== 1'b1 || posicion !== 2'd1) begin bad++; $display("FAIL to_key_wins got=f1 %b pos %0d want=1 1", f1, posicion); end
        press(1, 8'h76);
    endtask

    task automatic test_back_to_back();
        logic [1:0] want [0:3];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd0; want[3] = 2'd1;
        press(1, 8'h04);
        for (int i = 0; i < 4; i++) begin
            press(1, 8'h74);
            total++; if (posicion !== want[i]) begin bad++; $display("FAIL held_right%0d got=%0d want=%0d", i, posicion, want[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            press(1, 8'h75);
            total++; if (en_codigo !== 1'b1) begin bad++; $display("FAIL held_up%0d got=%b want=1", i, en_codigo); end
        end
        press(1, 8'h76);
    endtask

    task automatic test_async_reset();
        press(1, 8'h06);
        press(1, 8'h74);
        press(1, 8'h74);
        total++; if (f2 !== 1'b1 || posicion !== 2'd2) begin bad++; $display("FAIL ar_setup got=f2 %b pos %0d want=1 2", f2, posicion); end
        #2 key_valid = 1'b0; rst = 1'b1;
        #1;
        total++; if (f2 !== 1'b0 || posicion !== 2'd0) begin bad++; $display("FAIL ar_edit got=f2 %b pos %0d want=0 0", f2, posicion); end
        @(negedge clk) rst = 1'b0;
        model_reset();
        press(1, 8'h05);
        press(1, 8'h5A);
        total++; if (wr_rtc !== 1'b1 || wr_sel !== 2'd1) begin bad++; $display("FAIL ar_commit_setup got=wr %b sel %0d want=1 1", wr_rtc, wr_sel); end
        #2 key_valid = 1'b0; rst = 1'b1;
        #1;
        total++; if (wr_rtc !== 1'b0 || wr_sel !== 2'd0) begin bad++; $display("FAIL ar_commit got=wr %b sel %0d want=0 0", wr_rtc, wr_sel); end
        @(negedge clk) rst = 1'b0;
        model_reset();
        press(0, 8'h00);
        total++; if (wr_rtc !== 1'b0 || {f1, f2, f3} !== 3'b000) begin bad++; $display("FAIL ar_after got=wr %b flags %b want=0 000", wr_rtc, {f1, f2, f3}); end
    endtask

    task automatic test_random();
        logic       kv;
        logic [7:0] kc;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            kv = (c < 1500) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 4);
            kc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : key_tab[$urandom_range(0, 8)];
            press(kv, kc);
            total++; if (f1 !== (m_mode == 1 && !m_commit)) begin bad++; $display("FAIL rnd_f1 c=%0d got=%b want=%b", c, f1, (m_mode == 1 && !m_commit)); end
            total++; if (f2 !== (m_mode == 2 && !m_commit)) begin bad++; $display("FAIL rnd_f2 c=%0d got=%b want=%b", c, f2, (m_mode == 2 && !m_commit)); end
            total++; if (f3 !== (m_mode == 3 && !m_commit)) begin bad++; $display("FAIL rnd_f3 c=%0d got=%b want=%b", c, f3, (m_mode == 3 && !m_commit)); end
            total++; if (posicion !== 2'(m_pos)) begin bad++; $display("FAIL rnd_pos c=%0d got=%0d want=%0d", c, posicion, m_pos); end
            total++; if (en_codigo !== exp_en) begin bad++; $display("FAIL rnd_en c=%0d got=%b want=%b", c, en_codigo, exp_en); end
            if (exp_en) begin
                total++; if (key_code_out !== exp_kco) begin bad++; $display("FAIL rnd_kco c=%0d got=%h want=%h", c, key_code_out, exp_kco); end
            end
            total++; if (wr_rtc !== exp_wr || wr_sel !== exp_wsel) begin bad++; $display("FAIL rnd_wr c=%0d got=%b/%0d want=%b/%0d", c, wr_rtc, wr_sel, exp_wr, exp_wsel); end
        end
    endtask

    initial begin
        key_tab[0] = 8'h05; key_tab[1] = 8'h06; key_tab[2] = 8'h04;
        key_tab[3] = 8'h6B; key_tab[4] = 8'h74; key_tab[5] = 8'h75;
        key_tab[6] = 8'h72; key_tab[7] = 8'h5A; key_tab[8] = 8'h76;
        model_reset();
        test_reset();
        test_navigation();
        test_updown();
        test_switch_commit();
        test_esc_idle();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
